// File: rtl/tick_meter_pkg.sv
// Shared types and constants for the tick period meter.
// The optional min/max statistics are enabled with TICK_METER_STATS_EN.
package tick_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOST
    } tm_state_t;

    localparam int unsigned TICK_CNT_W = 16;

endpackage

// File: rtl/tick_sync_edge.sv
// Multi-flop synchronizer for an asynchronous tick line followed by a registered
// rising-edge detector; a held-high input produces a single one-cycle rise.
module tick_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync   <= '0;
            sync_d <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], d};
            sync_d <= sync[SYNC_STAGES-1];
            rise   <= sync[SYNC_STAGES-1] & ~sync_d;
        end
    end

endmodule

// File: rtl/tick_period_meter.sv
// Measures the clk-cycle spacing of rising edges on tick_in, flags lock and lost ticks.
// Define TICK_METER_STATS_EN to add min_period/max_period outputs.
module tick_period_meter
    import tick_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = 30,
    parameter int unsigned TIMEOUT     = 100_000_000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick_in,
    input  logic                  clear,
    output logic [CNT_W-1:0]      period_out,
    output logic                  period_valid,
    output logic                  locked,
    output logic                  timeout,
    output logic [TICK_CNT_W-1:0] tick_count
`ifdef TICK_METER_STATS_EN
    ,
    output logic [CNT_W-1:0]      min_period,
    output logic [CNT_W-1:0]      max_period
`endif
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    // clear must also flush the synchronizer so a stale edge cannot survive it
    logic sync_rst_n;
    logic rise;
    assign sync_rst_n = rst_n & ~clear;

    tick_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk   (clk),
        .rst_n (sync_rst_n),
        .d     (tick_in),
        .rise  (rise)
    );

    tm_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] prev_period;
    logic             period_done;

    assign period_done = (state == MEASURE) && rise;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state        <= IDLE;
            cnt          <= '0;
            prev_period  <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
            tick_count   <= '0;
        end else begin
            period_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rise) begin
                        state <= MEASURE;
                        cnt   <= CNT_W'(1);
                    end
                end
                MEASURE: begin
                    // An edge landing exactly on TIMEOUT is still a valid period
                    if (period_done) begin
                        period_out   <= cnt;
                        period_valid <= 1'b1;
                        tick_count   <= tick_count + TICK_CNT_W'(1);
                        locked       <= (cnt == prev_period);
                        prev_period  <= cnt;
                        cnt          <= CNT_W'(1);
                    end else if (cnt == TIMEOUT_CNT) begin
                        state   <= LOST;
                        timeout <= 1'b1;
                        locked  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LOST: begin
                    // Re-arm only; history is dropped so lock needs two fresh periods
                    if (rise) begin
                        state       <= MEASURE;
                        cnt         <= CNT_W'(1);
                        timeout     <= 1'b0;
                        prev_period <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef TICK_METER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            min_period <= '1;
            max_period <= '0;
        end else if (period_done) begin
            if (cnt < min_period) begin
                min_period <= cnt;
            end
            if (cnt > max_period) begin
                max_period <= cnt;
            end
        end
    end
`else
    // Statistics disabled: no min/max registers are built.
`endif

endmodule

// File: tb/tb_tick_period_meter.sv
// Scoreboard bench for tick_period_meter: a tick-level model predicts periods and timeouts.
// Define TICK_METER_STATS_EN to also check min_period/max_period.
module tb_tick_period_meter;

    localparam int unsigned CNT_W   = 30;
    localparam int unsigned TIMEOUT = 20;
    localparam int unsigned SYNC    = 2;
    // Input edge to FSM action: synchronizer stages plus the registered rise
    localparam int          LAT     = SYNC + 1;
    localparam longint      ALL_ONES = (64'd1 << CNT_W) - 1;
    localparam int          KP = 0;
    localparam int          KT = 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tick_in = 1'b0;
    logic             clear = 1'b0;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             locked;
    logic             timeout;
    logic [15:0]      tick_count;
`ifdef TICK_METER_STATS_EN
    logic [CNT_W-1:0] min_period;
    logic [CNT_W-1:0] max_period;
`endif

    tick_period_meter #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_in      (tick_in),
        .clear        (clear),
        .period_out   (period_out),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout),
        .tick_count   (tick_count)
`ifdef TICK_METER_STATS_EN
        ,
        .min_period   (min_period),
        .max_period   (max_period)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int     kind;
        int     cyc;
        longint period;
        longint locked;
        longint count;
        longint minp;
        longint maxp;
    } ev_t;

    ev_t q[$];

    // Tick-level model: input edge times in, predicted events out
    bit     m_armed;
    bit     m_lost;
    longint m_prev;
    longint m_count;
    longint m_min;
    longint m_max;
    int     m_last;

    task automatic model_reset();
        m_armed = 0; m_lost = 0; m_prev = 0; m_count = 0;
        m_min = ALL_ONES; m_max = 0; m_last = 0;
    endtask

    // Edge at input cycle e, with the gap to the following edge already known
    task automatic model_edge(input int e, input int next_gap);
        ev_t ev;
        if (m_armed && !m_lost) begin
            longint g = e - m_last;
            m_count = (m_count + 1) % 65536;
            if (g < m_min) m_min = g;
            if (g > m_max) m_max = g;
            ev.kind = KP; ev.cyc = e + LAT; ev.period = g; ev.locked = (g == m_prev);
            ev.count = m_count; ev.minp = m_min; ev.maxp = m_max;
            q.push_back(ev);
            m_prev = g;
        end else begin
            m_armed = 1; m_lost = 0; m_prev = 0;
        end
        m_last = e;
        if (next_gap > int'(TIMEOUT)) begin
            ev.kind = KT; ev.cyc = e + LAT + TIMEOUT; ev.period = 0; ev.locked = 0;
            ev.count = m_count; ev.minp = m_min; ev.maxp = m_max;
            q.push_back(ev);
            m_lost = 1;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_edge(input int w, input int g);
        model_edge(cyc + 1, g);
        tick_in = 1'b1;
        cycles(w);
        tick_in = 1'b0;
        cycles(g - w);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_period_out"}, period_out, 0);
        check({tag, "_period_valid"}, period_valid, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_tick_count"}, tick_count, 0);
`ifdef TICK_METER_STATS_EN
        check({tag, "_min_period"}, min_period, ALL_ONES);
        check({tag, "_max_period"}, max_period, 0);
`endif
    endtask

    // Monitor: every period_valid pulse or timeout rise must match the queue head
    logic to_prev = 1'b0;
    always @(negedge clk) begin
        if (period_valid === 1'b1 || (timeout === 1'b1 && to_prev === 1'b0)) begin
            if (q.size() == 0) begin
                check("event_expected", q.size(), 1);
            end else begin
                ev_t ev;
                ev = q.pop_front();
                check("event_kind", (period_valid === 1'b1) ? KP : KT, ev.kind);
                check("event_cycle", cyc, ev.cyc);
                check("event_locked", locked, ev.locked);
                check("event_tick_count", tick_count, ev.count);
                if (ev.kind == KP) begin
                    check("period_out", period_out, ev.period);
                    check("timeout_on_valid", timeout, 0);
`ifdef TICK_METER_STATS_EN
                    check("min_period", min_period, ev.minp);
                    check("max_period", max_period, ev.maxp);
`endif
                end
            end
        end
        to_prev <= timeout;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        int prev_g;
        int w;
        int r;

        model_reset();
        cycles(3);
        rst_n = 1'b1;
        check_reset_values("reset");
        cycles(2);

        // Steady 5-cycle ticks, then silence long enough to time out
        drive_edge(1, 5);
        drive_edge(1, 5);
        drive_edge(1, 5);
        drive_edge(1, 30);

        // Periods 5, 5, 7 after re-arming from LOST
        drive_edge(1, 5);
        drive_edge(2, 5);
        drive_edge(3, 7);
        drive_edge(1, 20);

        // Boundary: period exactly TIMEOUT, then one cycle beyond
        drive_edge(4, 20);
        drive_edge(1, TIMEOUT + 1);
        drive_edge(1, 2);
        drive_edge(1, 2);

        // Held-high input: one edge only
        drive_edge(50, 60);

        // Clear lands on the same cycle the FSM sees a rise
        drive_edge(1, 6);
        drive_edge(1, 6);
        tick_in = 1'b1;
        cycles(1);
        tick_in = 1'b0;
        cycles(LAT - 1);
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        model_reset();
        check_reset_values("clear");
        cycles(3);

        // Reset mid-measurement with the counter at 3
        model_edge(cyc + 1, 10);
        tick_in = 1'b1;
        cycles(1);
        tick_in = 1'b0;
        cycles(LAT + 2);
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        model_reset();
        check_reset_values("midreset");
        cycles(2);

        // Randomized spacing, with repeats to exercise lock
        prev_g = 5;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                g = prev_g;
            end else begin
                r = $urandom_range(0, 9);
                if (r < 7)       g = $urandom_range(2, 10);
                else if (r == 7) g = TIMEOUT;
                else if (r == 8) g = TIMEOUT + 1;
                else             g = $urandom_range(TIMEOUT + 2, 2 * TIMEOUT);
            end
            w = $urandom_range(1, g - 1);
            drive_edge(w, g);
            prev_g = g;
        end
        drive_edge(1, 2 * TIMEOUT + LAT + 5);

        check("pending_events", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
